// File: rtl/nandy_pkg.sv
// Shared definitions for the nandy instruction sequencer: FSM encoding,
// next-PC select codes and default address parameters.
package nandy_pkg;

    localparam int          DEF_PC_W         = 16;
    localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
    localparam logic [15:0] DEF_IRQ_VECTOR   = 16'h0008;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_EXEC2 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PCSEL_HOLD = 2'd0,
        PCSEL_INC  = 2'd1,
        PCSEL_JUMP = 2'd2,
        PCSEL_IRQ  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/nandy_pc_next.sv
// Combinational next-PC mux: hold, increment, jump target or interrupt vector.
// Increment wraps modulo 2^PC_W.
module nandy_pc_next
    import nandy_pkg::*;
#(
    parameter int              PC_W       = DEF_PC_W,
    parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(DEF_IRQ_VECTOR)
) (
    input  pc_sel_t         i_sel,
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_jump_target,
    output logic [PC_W-1:0] o_pc_inc,
    output logic [PC_W-1:0] o_pc_next
);

    assign o_pc_inc = i_pc + PC_W'(1);

    always_comb begin
        o_pc_next = i_pc;
        case (i_sel)
            PCSEL_HOLD: o_pc_next = i_pc;
            PCSEL_INC:  o_pc_next = o_pc_inc;
            PCSEL_JUMP: o_pc_next = i_jump_target;
            PCSEL_IRQ:  o_pc_next = IRQ_VECTOR;
        endcase
    end

endmodule

// File: rtl/nandy_sequencer.sv
// Instruction sequencer feeding the control decoder: fetches bytes, holds
// inst/cycle/carry/pc, and acts on control's sequencing strobes.
module nandy_sequencer
    import nandy_pkg::*;
#(
    parameter int              PC_W         = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR),
    parameter logic [PC_W-1:0] IRQ_VECTOR   = PC_W'(DEF_IRQ_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [7:0]      imem_rdata,
    input  logic            dmem_ready,
    input  logic            irq,
    input  logic            ctl_M,
    input  logic            ctl_MC,
    input  logic            ctl_J,
    input  logic            ctl_LJ,
    input  logic            ctl_LJR,
    input  logic            ctl_CLI,
    input  logic            ctl_WC,
    input  logic            alu_carry,
    input  logic [PC_W-1:0] jump_target,
    output logic [7:0]      inst,
    output logic            cycle,
    output logic            carry,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] link,
    output logic [PC_W-1:0] epc,
    output logic            ie,
    output logic            exec_valid,
    output logic            retire,
    output state_t          dbg_state
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_link;
    logic [PC_W-1:0] r_epc;
    logic [7:0]      r_inst;
    logic            r_carry;
    logic            r_ie;

    state_t          w_state_next;
    pc_sel_t         w_pc_sel;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_imem_req;
    logic            w_retire;
    logic            w_inst_load;
    logic            w_carry_load;
    logic            w_link_load;
    logic            w_epc_load;
    logic            w_ie_set;
    logic            w_ie_clr;

    nandy_pc_next #(
        .PC_W       (PC_W),
        .IRQ_VECTOR (IRQ_VECTOR)
    ) u_pc_next (
        .i_sel         (w_pc_sel),
        .i_pc          (r_pc),
        .i_jump_target (jump_target),
        .o_pc_inc      (w_pc_inc),
        .o_pc_next     (w_pc_next)
    );

    // Fetch handshake: imem_req is a request that stays high for every FETCH
    // cycle except the interrupt bubble; a byte transfers on any cycle where
    // imem_req & imem_ready, and imem_ready without imem_req is ignored.
    always_comb begin
        w_state_next = r_state;
        w_pc_sel     = PCSEL_HOLD;
        w_imem_req   = 1'b0;
        w_retire     = 1'b0;
        w_inst_load  = 1'b0;
        w_carry_load = 1'b0;
        w_link_load  = 1'b0;
        w_epc_load   = 1'b0;
        w_ie_set     = 1'b0;
        w_ie_clr     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (irq && r_ie) begin
                    w_pc_sel   = PCSEL_IRQ;
                    w_epc_load = 1'b1;
                    w_ie_clr   = 1'b1;
                end else begin
                    w_imem_req = 1'b1;
                    if (imem_ready) begin
                        w_inst_load  = 1'b1;
                        w_state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (ctl_MC) begin
                    w_state_next = ST_EXEC2;
                end else begin
                    w_retire     = 1'b1;
                    w_carry_load = ctl_WC;
                    w_pc_sel     = ctl_LJ ? PCSEL_JUMP : PCSEL_INC;
                    w_link_load  = ctl_LJR;
                    w_ie_set     = ctl_CLI;
                    w_state_next = ST_FETCH;
                end
            end
            ST_EXEC2: begin
                // J was resolved by control from the pre-update carry, so a
                // simultaneous WC cannot affect this cycle's branch.
                if (!(ctl_M && !dmem_ready)) begin
                    w_retire     = 1'b1;
                    w_carry_load = ctl_WC;
                    w_pc_sel     = ctl_J ? PCSEL_JUMP : PCSEL_INC;
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_VECTOR;
            r_inst  <= 8'h00;
            r_carry <= 1'b0;
            r_ie    <= 1'b0;
            r_link  <= '0;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_inst_load) begin
                r_inst <= imem_rdata;
            end
            if (w_carry_load) begin
                r_carry <= alu_carry;
            end
            if (w_link_load) begin
                r_link <= w_pc_inc;
            end
            if (w_epc_load) begin
                r_epc <= r_pc;
            end
            if (w_ie_clr) begin
                r_ie <= 1'b0;
            end else if (w_ie_set) begin
                r_ie <= 1'b1;
            end
        end
    end

    assign imem_addr  = r_pc;
    assign imem_req   = w_imem_req && !rst;
    assign inst       = r_inst;
    assign cycle      = (r_state == ST_EXEC2);
    assign carry      = r_carry;
    assign pc         = r_pc;
    assign link       = r_link;
    assign epc        = r_epc;
    assign ie         = r_ie;
    assign exec_valid = (r_state != ST_FETCH);
    assign retire     = w_retire && !rst;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_nandy_sequencer.sv
// Directed bench for nandy_sequencer: control strobes are driven by hand and
// each retired instruction's resulting PC is checked through an expected queue.
module tb_nandy_sequencer;
    import nandy_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [7:0]  imem_rdata;
    logic        dmem_ready;
    logic        irq;
    logic        ctl_M, ctl_MC, ctl_J, ctl_LJ, ctl_LJR, ctl_CLI, ctl_WC;
    logic        alu_carry;
    logic [15:0] jump_target;
    logic [7:0]  inst;
    logic        cycle;
    logic        carry;
    logic [15:0] pc;
    logic [15:0] link;
    logic [15:0] epc;
    logic        ie;
    logic        exec_valid;
    logic        retire;
    state_t      dbg_state;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_q[$];
    logic        retire_seen;

    nandy_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .dmem_ready  (dmem_ready),
        .irq         (irq),
        .ctl_M       (ctl_M),
        .ctl_MC      (ctl_MC),
        .ctl_J       (ctl_J),
        .ctl_LJ      (ctl_LJ),
        .ctl_LJR     (ctl_LJR),
        .ctl_CLI     (ctl_CLI),
        .ctl_WC      (ctl_WC),
        .alu_carry   (alu_carry),
        .jump_target (jump_target),
        .inst        (inst),
        .cycle       (cycle),
        .carry       (carry),
        .pc          (pc),
        .link        (link),
        .epc         (epc),
        .ie          (ie),
        .exec_valid  (exec_valid),
        .retire      (retire),
        .dbg_state   (dbg_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: PC after each retire must match the next expected entry.
    initial retire_seen = 1'b0;
    always @(negedge clk) begin
        if (retire_seen) begin
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check_eq("sb_pc", 32'(pc), 32'(exp_q.pop_front()));
            end
        end
        retire_seen = retire && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        ctl_M = 0; ctl_MC = 0; ctl_J = 0; ctl_LJ = 0;
        ctl_LJR = 0; ctl_CLI = 0; ctl_WC = 0;
        alu_carry = 0;
        jump_target = 16'h0000;
    endtask

    // Present one byte in FETCH and step into EXEC.
    task automatic fetch(input logic [7:0] b, input logic [15:0] exp_addr);
        imem_rdata = b;
        imem_ready = 1'b1;
        #1;
        check_eq("fetch_req", 32'(imem_req), 1);
        check_eq("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        tick();
        imem_ready = 1'b0;
        check_eq("exec_inst", 32'(inst), 32'(b));
        check_eq("exec_valid", 32'(exec_valid), 1);
        check_eq("exec_cycle", 32'(cycle), 0);
    endtask

    task automatic single_op(input logic [7:0] b, input logic [15:0] addr, input logic [15:0] nxt);
        fetch(b, addr);
        #1;
        check_eq("exec_retire", 32'(retire), 1);
        exp_q.push_back(nxt);
        tick();
        check_eq("back_to_fetch", 32'(dbg_state), 32'(ST_FETCH));
        check_eq("op_pc", 32'(pc), 32'(nxt));
        clr_ctl();
    endtask

    task automatic mem_op(input logic [7:0] b, input logic [15:0] addr, input int stalls,
                          input logic [15:0] nxt);
        fetch(b, addr);
        #1;
        check_eq("exec_mc_retire", 32'(retire), 0);
        tick();
        ctl_WC = 1'b0;
        for (int k = 0; k <= stalls; k++) begin
            dmem_ready = (k == stalls);
            #1;
            check_eq("exec2_cycle", 32'(cycle), 1);
            check_eq("exec2_retire", 32'(retire), 32'(k == stalls));
            check_eq("exec2_pc_hold", 32'(pc), 32'(addr));
            if (k == stalls) exp_q.push_back(nxt);
            tick();
        end
        dmem_ready = 1'b0;
        check_eq("mem_pc", 32'(pc), 32'(nxt));
        check_eq("mem_exec_valid", 32'(exec_valid), 0);
        clr_ctl();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 8'h00;
        dmem_ready = 1'b0;
        irq = 1'b0;
        clr_ctl();

        // Reset held for two edges
        tick();
        #1;
        check_eq("rst_req", 32'(imem_req), 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_pc", 32'(pc), 32'h0000);
        check_eq("rst_cycle", 32'(cycle), 0);
        check_eq("rst_carry", 32'(carry), 0);
        check_eq("rst_ie", 32'(ie), 0);
        check_eq("rst_exec_valid", 32'(exec_valid), 0);
        check_eq("rst_inst", 32'(inst), 32'h00);
        check_eq("rst_link", 32'(link), 32'h0000);
        check_eq("rst_epc", 32'(epc), 32'h0000);
        check_eq("post_rst_req", 32'(imem_req), 1);

        // Single-cycle op
        single_op(8'h41, 16'h0000, 16'h0001);

        // Memory op with three stall cycles
        ctl_MC = 1; ctl_M = 1;
        mem_op(8'h80, 16'h0001, 3, 16'h0002);

        // Set carry=1
        ctl_WC = 1; alu_carry = 1;
        single_op(8'h41, 16'h0002, 16'h0003);
        check_eq("carry_set", 32'(carry), 1);

        // Conditional jump not taken; WC in the MC cycle must not touch carry
        ctl_MC = 1; ctl_WC = 1; alu_carry = 0; jump_target = 16'h1234;
        mem_op(8'hF0, 16'h0003, 0, 16'h0004);
        check_eq("carry_kept_mc", 32'(carry), 1);

        // Clear carry
        ctl_WC = 1; alu_carry = 0;
        single_op(8'h41, 16'h0004, 16'h0005);
        check_eq("carry_clr", 32'(carry), 0);

        // Conditional jump taken
        ctl_MC = 1; ctl_J = 1; jump_target = 16'h1234;
        mem_op(8'hF0, 16'h0005, 0, 16'h1234);

        // Long jump to 0x0010, then LJR
        ctl_LJ = 1; jump_target = 16'h0010;
        single_op(8'h41, 16'h1234, 16'h0010);
        ctl_LJ = 1; ctl_LJR = 1; jump_target = 16'h0200;
        single_op(8'h14, 16'h0010, 16'h0200);
        check_eq("ljr_link", 32'(link), 32'h0011);

        // Enable interrupts, landing at 0x0033
        ctl_LJ = 1; ctl_CLI = 1; jump_target = 16'h0033;
        single_op(8'h12, 16'h0200, 16'h0033);
        check_eq("cli_ie", 32'(ie), 1);

        // Interrupt entry: one bubble, fetch byte offered but not taken
        irq = 1'b1;
        imem_rdata = 8'hAA;
        imem_ready = 1'b1;
        #1;
        check_eq("irq_bubble_req", 32'(imem_req), 0);
        tick();
        imem_ready = 1'b0;
        check_eq("irq_epc", 32'(epc), 32'h0033);
        check_eq("irq_pc", 32'(pc), 32'h0008);
        check_eq("irq_ie", 32'(ie), 0);
        check_eq("irq_state", 32'(dbg_state), 32'(ST_FETCH));
        check_eq("irq_inst_kept", 32'(inst), 32'h12);
        #1;
        check_eq("irq_masked_req", 32'(imem_req), 1);

        // Return via CLI; irq still high but ignored outside FETCH
        ctl_LJ = 1; ctl_CLI = 1; jump_target = 16'h0033;
        single_op(8'h12, 16'h0008, 16'h0033);
        check_eq("ret_ie", 32'(ie), 1);
        check_eq("pending_irq_req", 32'(imem_req), 0);
        irq = 1'b0;
        #1;
        check_eq("no_irq_req", 32'(imem_req), 1);

        // PC and link wrap at 0xFFFF
        ctl_LJ = 1; jump_target = 16'hFFFF;
        single_op(8'h41, 16'h0033, 16'hFFFF);
        ctl_LJR = 1;
        single_op(8'h41, 16'hFFFF, 16'h0000);
        check_eq("wrap_link", 32'(link), 32'h0000);

        #20;
        check_eq("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nandy_sequencer.md
Name: nandy_sequencer

Overview:
- Instruction-sequencing stage directly upstream of the `control` decoder.
- Fetches instruction bytes and holds the instruction register, `cycle` phase bit, carry flag and program counter that `control` consumes.
- Acts on `control`'s sequencing outputs (MC, J, LJ, LJR, CLI, WC) to advance the PC, enter the second cycle of memory instructions, and take interrupts at instruction boundaries.

Parameters:
- PC_W, 16, program counter / instruction address width.
- RESET_VECTOR, 16'h0000, PC value after reset.
- IRQ_VECTOR, 16'h0008, PC loaded on interrupt entry.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_req  out  1  fetch request.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  8  fetched instruction byte.
- dmem_ready  in  1  data-memory access complete (cycle-1 memory ops).
- irq  in  1  level interrupt request.
- ctl_M, ctl_MC, ctl_J, ctl_LJ, ctl_LJR, ctl_CLI, ctl_WC  in  1 each  decoded strobes from control.
- alu_carry  in  1  carry produced by the datapath this cycle.
- jump_target  in  PC_W  target address from datapath registers.
- inst  out  8  instruction register, to control.
- cycle  out  1  phase bit, to control.
- carry  out  1  carry flag, to control.
- pc  out  PC_W  current PC.
- link  out  PC_W  return address saved by LJR.
- epc  out  PC_W  PC saved on interrupt entry.
- ie  out  1  interrupt enable.
- exec_valid  out  1  inst/cycle valid; datapath gates writes with it.
- retire  out  1  one-cycle pulse on the instruction's final cycle.

Behaviour:
- Reset (rst=1 at posedge, overrides everything):
  - state=FETCH, pc=RESET_VECTOR, inst=8'h00.
  - cycle=0, carry=0, ie=0, link=0, epc=0.
  - imem_req=0 during the reset cycle.
- States: FETCH, EXEC, EXEC2.
  - cycle=1 only in EXEC2.
  - exec_valid=1 in EXEC and EXEC2.
- FETCH:
  - If irq & ie: epc<=pc, pc<=IRQ_VECTOR, ie<=0, stay in FETCH, imem_req=0 (one bubble).
  - Else imem_req=1, imem_addr=pc.
  - On imem_ready: inst<=imem_rdata, go to EXEC next cycle.
  - Fetch latency: minimum 1 cycle from request to EXEC.
- EXEC (cycle=0):
  - If ctl_MC: go to EXEC2; pc, carry and ie unchanged.
  - Else retire=1 and:
    - carry<=alu_carry if ctl_WC.
    - pc<=jump_target if ctl_LJ, else pc+1.
    - link<=pc+1 if ctl_LJR.
    - ie<=1 if ctl_CLI.
    - Go to FETCH.
- EXEC2 (cycle=1):
  - If ctl_M & ~dmem_ready: hold; all state unchanged, retire=0.
  - Else retire=1:
    - pc<=jump_target if ctl_J, else pc+1.
    - carry<=alu_carry if ctl_WC.
    - Go to FETCH.
- Carry ordering: J is evaluated by control against the carry value before any update in the same cycle.
- PC arithmetic: modulo 2^PC_W; pc+1 at max wraps to 0. link wraps the same way.
- Ignored inputs:
  - imem_ready outside FETCH.
  - dmem_ready outside EXEC2.
  - irq outside FETCH; it is sampled only at the instruction boundary, and a pending irq is taken on the first FETCH cycle.
- ctl_LJ and ctl_J are never both asserted; if they are, behaviour is undefined.
- Minimum instruction time: 2 cycles for a single-cycle op, 3 for a memory op (plus stalls).

Decomposition:
- Shared package `nandy_pkg`:
  - State encoding (FETCH=2'd0, EXEC=2'd1, EXEC2=2'd2).
  - RESET_VECTOR and IRQ_VECTOR defaults.
  - PC_W.
- Sub-module: `nandy_pc_next`, combinational next-PC mux (irq vector / jump_target / pc+1) shared with future branch logic. The FSM stays in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 → pc=0x0000, cycle=0, carry=0, ie=0, exec_valid=0; imem_req=1 on the first post-reset cycle.
- Single-cycle op: imem_rdata=0x41, imem_ready=1 → EXEC for 1 cycle with retire=1, pc 0x0000→0x0001, back to FETCH; total 2 cycles.
- Memory op: 0x80 with dmem_ready low for 3 cycles (ctl_M=1) → cycle=1 held 4 cycles, retire once, pc+1 once.
- Conditional jump 0xF0, jump_target=0x1234:
  - carry=1 (ctl_J=0) → pc=old+1.
  - carry=0 (ctl_J=1) → pc=0x1234.
- LJR 0x14 at pc=0x0010, jump_target=0x0200, ctl_LJ=ctl_LJR=1 → link=0x0011, pc=0x0200.
- Interrupt: ie=1, irq=1 at FETCH with pc=0x0033 → epc=0x0033, pc=0x0008, ie=0, one bubble with imem_req=0. Then CLI 0x12 (ctl_LJ=ctl_CLI=1, jump_target=0x0033) → ie=1, pc=0x0033.
